shift_unit: RTL and testbench
=============================

// Module: shift_unit
// PURPOSE
//   Parametrised multi-cycle shifter for the datapath ALU; supersedes the fixed 16-bit shifter.
//   Four modes: SLL, SRL, SRA and ROR. Shifts STEP bit positions per clock until shamt is consumed.
//   Valid/ready handshake on the input and output sides, so the ALU/control FSM can stall on it.
// PARAMETERS
//   WIDTH   16                 data width in bits; power of 2, 8..64
//   STEP    1                  max bit positions shifted per clock; power of 2, 1..WIDTH/2
//   SHAMT_W $clog2(WIDTH)      shift-amount width (derived; do not override)
// PORTS
//   clk        in   1        rising-edge clock
//   rst        in   1        asynchronous reset, active-low
//   in_valid   in   1        request present on data_in/shamt/mode
//   in_ready   out  1        unit can accept a request (state IDLE)
//   data_in    in   WIDTH    operand
//   shamt      in   SHAMT_W  shift amount, 0..WIDTH-1
//   mode       in   2        00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right)
//   out_valid  out  1        result valid (state DONE)
//   out_ready  in   1        consumer takes result
//   data_out   out  WIDTH    shifted result
//   carry_out  out  1        last bit shifted out; ROR: data_out[WIDTH-1]; shamt=0: 0
//   busy       out  1        high in SHIFT or DONE
// BEHAVIOUR
//   Reset: rst low forces state=IDLE immediately, regardless of clk.
//     data_out=0, carry_out=0, out_valid=0, busy=0, in_ready=1.
//     A request in flight is discarded; no output is produced for it.
//   FSM: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE
//     in_ready=1.
//     On in_valid at a clk edge: latch data_in into the working register, shamt into cnt, mode.
//     Clear carry; go to SHIFT.
//   SHIFT
//     Each edge: amt = min(STEP, cnt). Shift the working register by amt per mode; cnt -= amt.
//     carry <= last bit moved out; unchanged when amt=0.
//     If cnt <= STEP (including cnt=0), go to DONE on the same edge.
//   Latency: out_valid rises max(1, ceil(shamt/STEP)) edges after the accept edge.
//     Example: STEP=1, shamt=4 -> 4 edges; shamt=0 -> 1 edge.
//   Shift fill rules:
//     SLL fills zeros at the LSB end; SRL fills zeros at the MSB end.
//     SRA replicates the original MSB; ROR feeds the LSB into the MSB.
//   Result = same as a single combinational shift of data_in by shamt.
//     Intermediate values are never visible on data_out; data_out updates only on entry to DONE.
//   DONE
//     out_valid=1; data_out and carry_out are held stable until out_ready=1 at an edge.
//     Then go to IDLE. in_ready=0 in SHIFT and DONE; no request is accepted until IDLE.
//   data_out keeps its last value in IDLE (it is not cleared), until the next DONE or a reset.
//   shamt >= WIDTH cannot occur by width; no truncation logic required.
//   in_valid while busy is ignored; the requester holds it until in_ready.
//   mode and shamt are sampled only at the accept edge; later changes have no effect.
// TESTING
//   1. W16/S1: 0x0001 SLL 4 -> data_out 0x0010, carry 0, out_valid 4 edges after accept.
//   2. W16/S1: 0x8000 SRA 15 -> 0xFFFF, carry 0; 0x8000 SRL 15 -> 0x0001.
//   3. W16/S1: 0x001A ROR 1 -> 0x000D, carry 0; 0xFFFF SRL 0 -> 0xFFFF, carry 0, latency 1.
//   4. W16/S4: 0x002E SLL 9 -> 0x5C00, carry 0, latency 3.
//      0x00F0 SRL 5 -> 0x0007, carry 1, latency 2.
//   5. Hold out_ready=0 for 5 cycles in DONE -> out_valid and data_out stable, in_ready=0.
//      Release -> IDLE next edge.
//   6. Drop rst mid-SHIFT, between clk edges -> outputs reset at once.
//      After release, a new request (0x0030 SLL 2 -> 0x00C0) completes correctly.

Source files
------------

// File: rtl/shift_unit.sv
// Multi-cycle barrel-less shifter: moves up to STEP bit positions per clock in
// SLL/SRL/SRA/ROR modes, with valid/ready handshakes on both sides.
module shift_unit #(
  parameter int WIDTH   = 16,
  parameter int STEP    = 1,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   data_out,
  output logic               carry_out,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {SLL = 2'b00, SRL = 2'b01, SRA = 2'b10, ROR = 2'b11} mode_t;

  localparam logic [SHAMT_W-1:0] STEP_C = SHAMT_W'(STEP);

  state_t             state;
  mode_t              md;
  logic [WIDTH-1:0]   work;
  logic [SHAMT_W-1:0] cnt;
  logic               carry;

  logic [SHAMT_W-1:0] amt;
  logic [SHAMT_W-1:0] out_idx;
  logic [WIDTH-1:0]   shifted;
  logic               shifted_carry;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    amt           = (cnt < STEP_C) ? cnt : STEP_C;
    shifted       = work;
    shifted_carry = carry;
    out_idx       = amt - SHAMT_W'(1);
    if (amt != '0) begin
      unique case (md)
        SLL: begin
          shifted = work << amt;
          // WIDTH is a power of two, so 0 - amt wraps to WIDTH - amt: the last bit out.
          out_idx = '0 - amt;
        end
        SRL: shifted = work >> amt;
        SRA: shifted = $signed(work) >>> amt;
        ROR: shifted = WIDTH'({work, work} >> amt);
      endcase
      shifted_carry = work[out_idx];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      md        <= SLL;
      work      <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      data_out  <= '0;
      carry_out <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          work  <= data_in;
          cnt   <= shamt;
          md    <= mode_t'(mode);
          carry <= 1'b0;
          state <= SHIFT;
        end
        SHIFT: begin
          work  <= shifted;
          cnt   <= cnt - amt;
          carry <= shifted_carry;
          // Only the final result is published; intermediate steps stay internal.
          if (cnt <= STEP_C) begin
            data_out  <= shifted;
            carry_out <= shifted_carry;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_shift_unit.sv
// Self-checking bench: STEP=1 and STEP=4 instances share stimulus and are
// compared against an arithmetic reference of the four shift modes.
module tb_shift_unit;
  localparam int W = 16;
  localparam logic [1:0] SLL = 2'b00, SRL = 2'b01, SRA = 2'b10, ROR = 2'b11;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, out_ready;
  logic [W-1:0] data_in;
  logic [3:0]   shamt;
  logic [1:0]   mode;

  logic         in_ready1, out_valid1, carry1, busy1;
  logic [W-1:0] dout1;
  logic         in_ready4, out_valid4, carry4, busy4;
  logic [W-1:0] dout4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  shift_unit #(.WIDTH(W), .STEP(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .data_in(data_in), .shamt(shamt), .mode(mode), .out_valid(out_valid1),
    .out_ready(out_ready), .data_out(dout1), .carry_out(carry1), .busy(busy1)
  );

  shift_unit #(.WIDTH(W), .STEP(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .data_in(data_in), .shamt(shamt), .mode(mode), .out_valid(out_valid4),
    .out_ready(out_ready), .data_out(dout4), .carry_out(carry4), .busy(busy4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Result of one combinational shift of d by sh, straight from the mode rules.
  function automatic void ref_model(input logic [W-1:0] d, input int sh, input logic [1:0] m,
                                    output logic [W-1:0] r, output logic c);
    int full;
    c = 1'b0;
    case (m)
      SLL: begin
        r = d << sh;
        if (sh != 0) c = d[W - sh];
      end
      SRL: begin
        r = d >> sh;
        if (sh != 0) c = d[sh - 1];
      end
      SRA: begin
        r = $signed(d) >>> sh;
        if (sh != 0) c = d[sh - 1];
      end
      default: begin
        full = (int'(d) >> sh) | (int'(d) << (W - sh));
        r = W'(full);
        if (sh != 0) c = r[W-1];
      end
    endcase
  endfunction

  function automatic int exp_lat(input int sh, input int step);
    return (sh == 0) ? 1 : (sh + step - 1) / step;
  endfunction

  task automatic check_idle_reset(input string tag);
    check({tag, "_dout1"}, dout1, 0);
    check({tag, "_dout4"}, dout4, 0);
    check({tag, "_carry1"}, carry1, 0);
    check({tag, "_carry4"}, carry4, 0);
    check({tag, "_ovalid1"}, out_valid1, 0);
    check({tag, "_ovalid4"}, out_valid4, 0);
    check({tag, "_busy1"}, busy1, 0);
    check({tag, "_busy4"}, busy4, 0);
    check({tag, "_iready1"}, in_ready1, 1);
    check({tag, "_iready4"}, in_ready4, 1);
  endtask

  task automatic run_req(input logic [W-1:0] d, input int sh, input logic [1:0] m, input int hold);
    logic [W-1:0] r;
    logic         c;
    int           lat1, lat4;
    ref_model(d, sh, m, r, c);

    @(negedge clk);
    data_in   = d;
    shamt     = 4'(sh);
    mode      = m;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    check("accept_iready1", in_ready1, 1);
    check("accept_iready4", in_ready4, 1);
    @(posedge clk);
    // Garbage held on the request side must be ignored while busy.
    #1;
    data_in = W'($urandom);
    shamt   = 4'($urandom);
    mode    = 2'($urandom);

    lat1 = 0;
    lat4 = 0;
    for (int e = 1; e <= 40 && (lat1 == 0 || lat4 == 0); e++) begin
      @(posedge clk);
      #1;
      if (lat1 == 0 && out_valid1) lat1 = e;
      if (lat4 == 0 && out_valid4) lat4 = e;
    end
    check("latency_s1", lat1, exp_lat(sh, 1));
    check("latency_s4", lat4, exp_lat(sh, 4));

    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      check("dout_s1", dout1, r);
      check("carry_s1", carry1, c);
      check("dout_s4", dout4, r);
      check("carry_s4", carry4, c);
      check("done_ovalid1", out_valid1, 1);
      check("done_ovalid4", out_valid4, 1);
      check("done_iready1", in_ready1, 0);
      check("done_iready4", in_ready4, 0);
      check("done_busy1", busy1, 1);
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_ovalid1", out_valid1, 0);
    check("release_ovalid4", out_valid4, 0);
    check("release_iready1", in_ready1, 1);
    check("release_iready4", in_ready4, 1);
    check("idle_keep_dout1", dout1, r);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_in   = '0;
    shamt     = '0;
    mode      = SLL;
    #12;
    check_idle_reset("reset");
    @(negedge clk);
    rst = 1'b1;

    run_req(16'h0001, 4, SLL, 5);
    run_req(16'h8000, 15, SRA, 0);
    run_req(16'h8000, 15, SRL, 0);
    run_req(16'h001A, 1, ROR, 0);
    run_req(16'hFFFF, 0, SRL, 1);
    run_req(16'h002E, 9, SLL, 0);
    run_req(16'h00F0, 5, SRL, 0);
    run_req(16'h8001, 15, ROR, 0);

    // Asynchronous reset in the middle of a long shift.
    @(negedge clk);
    data_in  = 16'hABCD;
    shamt    = 4'd15;
    mode     = SRA;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1 check_idle_reset("midreset");
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_busy1", busy1, 0);
    check("post_reset_ovalid1", out_valid1, 0);
    run_req(16'h0030, 2, SLL, 1);

    repeat (150) run_req(W'($urandom), $urandom_range(0, W - 1), 2'($urandom_range(0, 3)),
                         $urandom_range(0, 3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
